// File: rtl/slot_sequencer.sv
// slot_sequencer: walks the slot table, dispatches VALID descriptors to the DMA engine and writes back status/profile
module slot_sequencer #(
    parameter int INDEX_WIDTH    = 2,
    parameter int SRC_ADDR_WIDTH = 32,
    parameter int SRC_SIZE_WIDTH = 26,
    parameter int DST_ADDR_WIDTH = 32,
    parameter int DST_SIZE_WIDTH = 26,
    parameter int STATUS_WIDTH   = 2,
    parameter int PROFILE_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    output logic                      busy,
    output logic                      seq_done,
    output logic                      seq_aborted,
    output logic                      err_sticky,
    output logic [INDEX_WIDTH-1:0]    rd_index,
    input  logic [SRC_ADDR_WIDTH-1:0] rd_src_addr,
    input  logic [SRC_SIZE_WIDTH-1:0] rd_src_size,
    input  logic [DST_ADDR_WIDTH-1:0] rd_des_addr,
    input  logic [DST_SIZE_WIDTH-1:0] rd_des_size,
    input  logic [STATUS_WIDTH-1:0]   rd_status,
    output logic [INDEX_WIDTH-1:0]    wr_index,
    output logic [STATUS_WIDTH-1:0]   wr_status,
    output logic [PROFILE_WIDTH-1:0]  wr_profile,
    output logic                      set_status,
    output logic                      set_profile,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [SRC_ADDR_WIDTH-1:0] cmd_src_addr,
    output logic [SRC_SIZE_WIDTH-1:0] cmd_src_size,
    output logic [DST_ADDR_WIDTH-1:0] cmd_des_addr,
    output logic [DST_SIZE_WIDTH-1:0] cmd_des_size,
    input  logic                      dma_done,
    input  logic                      dma_err
);
    localparam logic [STATUS_WIDTH-1:0] ST_EMPTY   = STATUS_WIDTH'(0);
    localparam logic [STATUS_WIDTH-1:0] ST_VALID   = STATUS_WIDTH'(1);
    localparam logic [STATUS_WIDTH-1:0] ST_RUNNING = STATUS_WIDTH'(2);
    localparam logic [STATUS_WIDTH-1:0] ST_DONE    = STATUS_WIDTH'(3);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_ISSUE, S_WAIT, S_WRBACK, S_NEXT, S_FINISH} state_t;

    state_t                   state;
    logic [INDEX_WIDTH-1:0]   idx;
    logic [PROFILE_WIDTH-1:0] count;
    logic [PROFILE_WIDTH-1:0] count_inc;
    logic                     abort_flag;
    logic                     cmd_fire;
    logic                     wb;
    logic                     stop;

    assign rd_index  = idx;
    assign count_inc = &count ? count : count + 1'b1;
    assign cmd_fire  = (state == S_ISSUE) && cmd_ready;
    // a completion in the handshake cycle counts as zero elapsed cycles
    assign wb        = (cmd_fire || state == S_WAIT) && (dma_done || dma_err);
    assign stop      = abort_flag || abort;

    // sequencer FSM with all outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            idx          <= '0;
            count        <= '0;
            abort_flag   <= 1'b0;
            busy         <= 1'b0;
            seq_done     <= 1'b0;
            seq_aborted  <= 1'b0;
            err_sticky   <= 1'b0;
            wr_index     <= '0;
            wr_status    <= '0;
            wr_profile   <= '0;
            set_status   <= 1'b0;
            set_profile  <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_src_addr <= '0;
            cmd_src_size <= '0;
            cmd_des_addr <= '0;
            cmd_des_size <= '0;
        end else begin
            set_status  <= 1'b0;
            set_profile <= 1'b0;
            seq_done    <= 1'b0;
            seq_aborted <= 1'b0;
            if (abort && state != S_IDLE && state != S_FINISH) abort_flag <= 1'b1;
            if (wb) begin
                set_status  <= 1'b1;
                set_profile <= 1'b1;
                wr_index    <= idx;
                wr_status   <= dma_err ? ST_EMPTY : ST_DONE;
                wr_profile  <= cmd_fire ? '0 : count_inc;
                err_sticky  <= err_sticky || dma_err;
            end
            case (state)
                S_IDLE: if (start) begin
                    err_sticky <= 1'b0;
                    idx        <= '0;
                    busy       <= 1'b1;
                    state      <= S_READ;
                end
                S_READ: if (rd_status == ST_VALID) begin
                    cmd_src_addr <= rd_src_addr;
                    cmd_src_size <= rd_src_size;
                    cmd_des_addr <= rd_des_addr;
                    cmd_des_size <= rd_des_size;
                    cmd_valid    <= 1'b1;
                    set_status   <= 1'b1;
                    wr_index     <= idx;
                    wr_status    <= ST_RUNNING;
                    state        <= S_ISSUE;
                end else begin
                    state <= S_NEXT;
                end
                S_ISSUE: if (cmd_ready) begin
                    cmd_valid <= 1'b0;
                    count     <= '0;
                    state     <= wb ? S_WRBACK : S_WAIT;
                end
                S_WAIT: begin
                    count <= count_inc;
                    if (wb) state <= S_WRBACK;
                end
                S_WRBACK: state <= S_NEXT;
                S_NEXT: if (stop || &idx) begin
                    seq_done    <= 1'b1;
                    seq_aborted <= stop;
                    state       <= S_FINISH;
                end else begin
                    idx   <= idx + 1'b1;
                    state <= S_READ;
                end
                S_FINISH: begin
                    abort_flag <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
